// File: rtl/wb_grf.sv
// Writeback stage: selects/extends the writeback datum, commits it to the 32x32 GRF,
// and serves the D-stage read ports with W->D bypass. Define WB_DISPLAY_EN for commit trace prints.
module wb_grf #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] W_PC,
  input  logic [31:0] W_CalcResult,
  input  logic [31:0] W_DMRD,
  input  logic [4:0]  W_RegAddr,
  input  logic        W_RegWrite,
  input  logic [1:0]  W_WDSel,
  input  logic [2:0]  W_LoadType,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  output logic [31:0] D_RD1,
  output logic [31:0] D_RD2,
  output logic [31:0] W_WD
);

  typedef enum logic [2:0] {
    LD_W   = 3'd0,
    LD_B   = 3'd1,
    LD_BU  = 3'd2,
    LD_H   = 3'd3,
    LD_HU  = 3'd4
  } load_type_e;

  typedef enum logic [1:0] {
    WD_CALC = 2'd0,
    WD_LOAD = 2'd1,
    WD_LINK = 2'd2,
    WD_ZERO = 2'd3
  } wd_sel_e;

  logic [31:0] regs [32];
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  logic        commit;

  // Byte/halfword lane is chosen by the low address bits carried in the calc result.
  always_comb begin
    load_byte = W_DMRD[7:0];
    case (W_CalcResult[1:0])
      2'd1:    load_byte = W_DMRD[15:8];
      2'd2:    load_byte = W_DMRD[23:16];
      2'd3:    load_byte = W_DMRD[31:24];
      default: load_byte = W_DMRD[7:0];
    endcase
    load_half = W_CalcResult[1] ? W_DMRD[31:16] : W_DMRD[15:0];

    load_data = W_DMRD;
    case (W_LoadType)
      LD_B:    load_data = {{24{load_byte[7]}}, load_byte};
      LD_BU:   load_data = {24'd0, load_byte};
      LD_H:    load_data = {{16{load_half[15]}}, load_half};
      LD_HU:   load_data = {16'd0, load_half};
      default: load_data = W_DMRD;
    endcase
  end

  always_comb begin
    W_WD = W_CalcResult;
    case (W_WDSel)
      WD_CALC: W_WD = W_CalcResult;
      WD_LOAD: W_WD = load_data;
      WD_LINK: W_WD = W_PC + 32'd8;
      WD_ZERO: W_WD = 32'd0;
      default: W_WD = W_CalcResult;
    endcase
  end

  assign commit = W_RegWrite && (W_RegAddr != 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (commit) begin
      regs[W_RegAddr] <= W_WD;
    end
  end

  // $0 never bypasses, so a discarded write to it stays invisible to decode.
  always_comb begin
    D_RD1 = 32'd0;
    D_RD2 = 32'd0;
    if (D_rs != 5'd0) begin
      D_RD1 = (commit && (D_rs == W_RegAddr)) ? W_WD : regs[D_rs];
    end
    if (D_rt != 5'd0) begin
      D_RD2 = (commit && (D_rt == W_RegAddr)) ? W_WD : regs[D_rt];
    end
  end

`ifdef WB_DISPLAY_EN
  always @(posedge clk) begin
    if (!reset && W_RegWrite) begin
      $display("@%h: $%d <= %h", W_PC, W_RegAddr, W_WD);
      if ((W_PC < RESET_PC) || (W_PC[1:0] != 2'b00)) begin
        $display("warning: illegal W_PC %h", W_PC);
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed spec cases followed by random traffic
// checked against an array-based register file model.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] W_PC, W_CalcResult, W_DMRD;
  logic [4:0]  W_RegAddr;
  logic        W_RegWrite;
  logic [1:0]  W_WDSel;
  logic [2:0]  W_LoadType;
  logic [4:0]  D_rs, D_rt;
  logic [31:0] D_RD1, D_RD2, W_WD;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rf [32];

  wb_grf dut (
    .clk(clk), .reset(reset), .W_PC(W_PC), .W_CalcResult(W_CalcResult),
    .W_DMRD(W_DMRD), .W_RegAddr(W_RegAddr), .W_RegWrite(W_RegWrite),
    .W_WDSel(W_WDSel), .W_LoadType(W_LoadType), .D_rs(D_rs), .D_rt(D_rt),
    .D_RD1(D_RD1), .D_RD2(D_RD2), .W_WD(W_WD)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] ref_wd(logic [31:0] pc, logic [31:0] calc,
                                         logic [31:0] dmrd, logic [1:0] sel,
                                         logic [2:0] lt);
    byte     sb;
    shortint sh;
    int      off;
    off = int'(calc[1:0]);
    sb  = byte'(dmrd >> (8 * off));
    sh  = shortint'(dmrd >> (16 * (off / 2)));
    case (sel)
      2'd0: return calc;
      2'd2: return pc + 32'd8;
      2'd3: return 32'd0;
      default: begin
        case (lt)
          3'd1: return 32'(sb);
          3'd2: return (dmrd >> (8 * off)) & 32'h0000_00FF;
          3'd3: return 32'(sh);
          3'd4: return (dmrd >> (16 * (off / 2))) & 32'h0000_FFFF;
          default: return dmrd;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] ref_read(logic [4:0] a);
    logic [31:0] wd;
    wd = ref_wd(W_PC, W_CalcResult, W_DMRD, W_WDSel, W_LoadType);
    if (a == 5'd0) return 32'd0;
    if (W_RegWrite && (a == W_RegAddr)) return wd;
    return model_rf[a];
  endfunction

  task automatic check_output(string tag, logic [31:0] observed, logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(logic [31:0] pc, logic [31:0] calc, logic [31:0] dmrd,
                                logic [4:0] addr, logic we, logic [1:0] sel,
                                logic [2:0] lt, logic [4:0] rs, logic [4:0] rt);
    W_PC = pc; W_CalcResult = calc; W_DMRD = dmrd; W_RegAddr = addr;
    W_RegWrite = we; W_WDSel = sel; W_LoadType = lt; D_rs = rs; D_rt = rt;
    #1;
  endtask

  // Advance one edge and mirror the commit in the model.
  task automatic clock_edge();
    logic [31:0] wd;
    wd = ref_wd(W_PC, W_CalcResult, W_DMRD, W_WDSel, W_LoadType);
    @(posedge clk);
    if (!reset && W_RegWrite && (W_RegAddr != 5'd0)) model_rf[W_RegAddr] = wd;
    #1;
  endtask

  task automatic check_load(logic [2:0] lt, logic [1:0] off, logic [31:0] expected, string tag);
    apply_stimulus(32'h3000, {30'd0, off}, 32'h80FF_7F01, 5'd0, 1'b0, 2'd1, lt, 5'd0, 5'd0);
    check_output(tag, W_WD, expected);
  endtask

  initial begin
    logic [31:0] lb_exp [4];
    lb_exp[0] = 32'h0000_0001; lb_exp[1] = 32'h0000_007F;
    lb_exp[2] = 32'hFFFF_FFFF; lb_exp[3] = 32'hFFFF_FF80;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

    reset = 1'b1;
    apply_stimulus(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 5'(i), 5'(31 - i));
      check_output("reset_rd1", D_RD1, 32'd0);
      check_output("reset_rd2", D_RD2, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    // $5 write then asynchronous reset with no clock edge.
    apply_stimulus(32'h3000, 32'h1234_5678, 32'd0, 5'd5, 1'b1, 2'd0, 3'd0, 5'd5, 5'd0);
    clock_edge();
    apply_stimulus(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 5'd5, 5'd5);
    check_output("r5_stored", D_RD1, 32'h1234_5678);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    check_output("r5_async_reset", D_RD1, 32'd0);
    check_output("r5_async_reset_rt", D_RD2, 32'd0);
    #1;
    reset = 1'b0;

    // Writes to $0 are discarded and never bypassed.
    apply_stimulus(32'h3000, 32'hDEAD_BEEF, 32'd0, 5'd0, 1'b1, 2'd0, 3'd0, 5'd0, 5'd0);
    check_output("r0_wd", W_WD, 32'hDEAD_BEEF);
    check_output("r0_no_bypass", D_RD1, 32'd0);
    clock_edge();
    check_output("r0_after_edge", D_RD1, 32'd0);

    for (int off = 0; off < 4; off++) check_load(3'd1, 2'(off), lb_exp[off], "lb");
    check_load(3'd2, 2'd3, 32'h0000_0080, "lbu_off3");
    check_load(3'd3, 2'd2, 32'hFFFF_80FF, "lh_off2");
    check_load(3'd4, 2'd0, 32'h0000_7F01, "lhu_off0");
    check_load(3'd0, 2'd2, 32'h80FF_7F01, "lw");
    check_load(3'd7, 2'd1, 32'h80FF_7F01, "lt7_as_lw");

    // Link value into $31, bypassed before the edge and stored after.
    apply_stimulus(32'h0000_3004, 32'd0, 32'd0, 5'd31, 1'b1, 2'd2, 3'd0, 5'd31, 5'd0);
    check_output("link_wd", W_WD, 32'h0000_300C);
    check_output("link_bypass", D_RD1, 32'h0000_300C);
    clock_edge();
    apply_stimulus(32'h0000_3010, 32'd0, 32'd0, 5'd31, 1'b0, 2'd2, 3'd0, 5'd31, 5'd31);
    check_output("link_stored", D_RD1, 32'h0000_300C);
    check_output("link_stored_rt", D_RD2, 32'h0000_300C);
    apply_stimulus(32'hFFFF_FFFC, 32'd0, 32'd0, 5'd1, 1'b0, 2'd2, 3'd0, 5'd0, 5'd0);
    check_output("link_wrap", W_WD, 32'h0000_0004);
    apply_stimulus(32'h3000, 32'h5555_5555, 32'd0, 5'd1, 1'b0, 2'd3, 3'd0, 5'd0, 5'd0);
    check_output("wdsel_zero", W_WD, 32'd0);

    // Dual-port bypass on $3.
    apply_stimulus(32'h3000, 32'h1, 32'd0, 5'd3, 1'b1, 2'd0, 3'd0, 5'd0, 5'd0);
    clock_edge();
    apply_stimulus(32'h3000, 32'h2, 32'd0, 5'd3, 1'b1, 2'd0, 3'd0, 5'd3, 5'd3);
    check_output("dual_bypass_rd1", D_RD1, 32'h2);
    check_output("dual_bypass_rd2", D_RD2, 32'h2);
    apply_stimulus(32'h3000, 32'h2, 32'd0, 5'd3, 1'b0, 2'd0, 3'd0, 5'd3, 5'd3);
    check_output("no_we_rd1", D_RD1, 32'h1);
    check_output("no_we_rd2", D_RD2, 32'h1);

    // Back-to-back writes to $7 with a $8 read in between.
    apply_stimulus(32'h3000, 32'hA, 32'd0, 5'd7, 1'b1, 2'd0, 3'd0, 5'd8, 5'd0);
    check_output("r8_before", D_RD1, 32'd0);
    clock_edge();
    apply_stimulus(32'h3000, 32'hB, 32'd0, 5'd7, 1'b1, 2'd0, 3'd0, 5'd8, 5'd7);
    check_output("r8_between", D_RD1, 32'd0);
    check_output("r7_bypass_b", D_RD2, 32'hB);
    clock_edge();
    apply_stimulus(32'h3000, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 3'd0, 5'd7, 5'd8);
    check_output("r7_final", D_RD1, 32'hB);
    check_output("r8_final", D_RD2, 32'd0);

    // Random traffic against the model, with an occasional asynchronous reset.
    for (int n = 0; n < 400; n++) begin
      apply_stimulus($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 31)));
      check_output("rand_wd", W_WD, ref_wd(W_PC, W_CalcResult, W_DMRD, W_WDSel, W_LoadType));
      check_output("rand_rd1", D_RD1, ref_read(D_rs));
      check_output("rand_rd2", D_RD2, ref_read(D_rt));
      if (n == 200) begin
        reset = 1'b1;
        #1;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        W_RegWrite = 1'b0;
        #1;
        check_output("rand_reset_rd1", D_RD1, ref_read(D_rs));
        clock_edge();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        clock_edge();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
